imem_uart_loader: RTL and testbench

- UART program loader: receives a framed byte stream on a serial pin, assembles little-endian 32-bit instruction words and drives the instruction-memory write port (we/a/wd).
- Holds the pipelined core in reset while a load is in progress, then releases it so execution starts at PC=0 with the new image.
- Fills instruction memory; the core fetches from that same memory.

---
 rtl/imem_uart_loader.sv | 256 +++++++++++++++++++++++++
 tb/tb_imem_uart_loader.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_uart_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_uart_loader
// Description : UART program loader. Receives 8N1 bytes on rx, parses a frame
//               (16-bit little-endian word count N, then N little-endian
//               32-bit words) and writes each word into instruction memory.
//               The core is held in reset while a frame is being loaded.
// Ports       : clk       - system clock
//               reset     - synchronous active-high reset
//               rx        - UART serial input (idle high, asynchronous)
//               we/a/wd   - imem write port (byte address = word index * 4)
//               busy      - frame load in progress
//               cpu_reset - core reset (reset OR busy)
//               done      - last frame completed successfully
//               err       - sticky framing / oversize error
// Revision    : 1.0 - initial release
// ============================================================================
module imem_uart_loader #(
    parameter int CLKS_PER_BIT = 868,   // must be >= 4
    parameter int MAX_WORDS    = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic        we,
    output logic [31:0] a,
    output logic [31:0] wd,
    output logic        busy,
    output logic        cpu_reset,
    output logic        done,
    output logic        err
);

    localparam int             c_CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0]    c_MAX_WORDS = 16'(MAX_WORDS);

    // RX state encoding
    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_START = 2'd1;
    localparam logic [1:0] R_DATA  = 2'd2;
    localparam logic [1:0] R_STOP  = 2'd3;

    // Loader state encoding
    localparam logic [1:0] L_IDLE  = 2'd0;
    localparam logic [1:0] L_CNT   = 2'd1;
    localparam logic [1:0] L_DATA  = 2'd2;
    localparam logic [1:0] L_DONE  = 2'd3;

    // ------------------------------------------------------------------
    // rx synchronizer; preset high so reset never looks like a start bit
    // ------------------------------------------------------------------
    logic r_rxMeta;
    logic r_rxSync;
    logic r_rxPrev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rxMeta <= 1'b1;
            r_rxSync <= 1'b1;
            r_rxPrev <= 1'b1;
        end else begin
            r_rxMeta <= rx;
            r_rxSync <= r_rxMeta;
            r_rxPrev <= r_rxSync;
        end
    end

    // ------------------------------------------------------------------
    // RX FSM
    // ------------------------------------------------------------------
    logic [1:0]         r_rxState;
    logic [1:0]         w_rxNext;
    logic [c_CNT_W-1:0] r_clkCnt;
    logic [2:0]         r_bitIdx;
    logic [7:0]         r_rxShift;   // holds the received byte after the stop bit
    logic               r_byteValid;
    logic               r_frameErr;

    wire w_cntBitLast  = (r_clkCnt == c_BIT_LAST);
    wire w_cntHalfLast = (r_clkCnt == c_HALF_LAST);

    always_ff @(posedge clk) begin
        if (reset) r_rxState <= R_IDLE;
        else       r_rxState <= w_rxNext;
    end

    always_comb begin
        w_rxNext = r_rxState;
        case (r_rxState)
            R_IDLE:  if (r_rxPrev && !r_rxSync) w_rxNext = R_START;
            R_START: if (w_cntHalfLast) w_rxNext = r_rxSync ? R_IDLE : R_DATA;
            R_DATA:  if (w_cntBitLast && (r_bitIdx == 3'd7)) w_rxNext = R_STOP;
            R_STOP:  if (w_cntBitLast) w_rxNext = R_IDLE;
            default: w_rxNext = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_clkCnt    <= '0;
            r_bitIdx    <= 3'd0;
            r_rxShift   <= 8'd0;
            r_byteValid <= 1'b0;
            r_frameErr  <= 1'b0;
        end else begin
            r_byteValid <= 1'b0;
            r_frameErr  <= 1'b0;
            case (r_rxState)
                R_IDLE: begin
                    r_clkCnt <= '0;
                    r_bitIdx <= 3'd0;
                end
                R_START: begin
                    // Counter restarts at the start-bit centre so later samples
                    // land mid-bit.
                    r_clkCnt <= w_cntHalfLast ? '0 : r_clkCnt + 1'b1;
                end
                R_DATA: begin
                    if (w_cntBitLast) begin
                        r_clkCnt  <= '0;
                        r_rxShift <= {r_rxSync, r_rxShift[7:1]};
                        r_bitIdx  <= r_bitIdx + 3'd1;
                    end else begin
                        r_clkCnt <= r_clkCnt + 1'b1;
                    end
                end
                R_STOP: begin
                    if (w_cntBitLast) begin
                        r_clkCnt <= '0;
                        if (r_rxSync) r_byteValid <= 1'b1;
                        else          r_frameErr  <= 1'b1;
                    end else begin
                        r_clkCnt <= r_clkCnt + 1'b1;
                    end
                end
                default: r_clkCnt <= '0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Loader FSM
    // ------------------------------------------------------------------
    logic [1:0]  r_ldState;
    logic [1:0]  w_ldNext;
    logic [7:0]  r_countLo;
    logic [15:0] r_wordCount;
    logic [15:0] r_wordIdx;
    logic [1:0]  r_byteIdx;
    logic [23:0] r_wordBuf;      // lanes 0..2; lane 3 comes straight from the byte

    wire [15:0] w_count    = {r_rxShift, r_countLo};
    wire        w_lastByte = (r_byteIdx == 2'd3);
    wire        w_lastWord = (r_wordIdx == (r_wordCount - 16'd1));

    always_ff @(posedge clk) begin
        if (reset) r_ldState <= L_IDLE;
        else       r_ldState <= w_ldNext;
    end

    always_comb begin
        w_ldNext = r_ldState;
        case (r_ldState)
            L_IDLE: if (r_byteValid) w_ldNext = L_CNT;
            L_CNT: begin
                if (r_frameErr) begin
                    w_ldNext = L_IDLE;
                end else if (r_byteValid) begin
                    if (w_count == 16'd0)             w_ldNext = L_DONE;
                    else if (w_count > c_MAX_WORDS)   w_ldNext = L_IDLE;
                    else                              w_ldNext = L_DATA;
                end
            end
            L_DATA: begin
                if (r_frameErr)                                    w_ldNext = L_IDLE;
                else if (r_byteValid && w_lastByte && w_lastWord)  w_ldNext = L_DONE;
            end
            L_DONE:  w_ldNext = L_IDLE;
            default: w_ldNext = L_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we          <= 1'b0;
            a           <= 32'd0;
            wd          <= 32'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            r_countLo   <= 8'd0;
            r_wordCount <= 16'd0;
            r_wordIdx   <= 16'd0;
            r_byteIdx   <= 2'd0;
            r_wordBuf   <= 24'd0;
        end else begin
            we <= 1'b0;
            if (r_frameErr) err <= 1'b1;
            case (r_ldState)
                L_IDLE: begin
                    if (r_byteValid) begin
                        r_countLo <= r_rxShift;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                    end
                end
                L_CNT: begin
                    if (r_frameErr) begin
                        busy <= 1'b0;
                        done <= 1'b0;
                    end else if (r_byteValid) begin
                        r_wordCount <= w_count;
                        r_wordIdx   <= 16'd0;
                        r_byteIdx   <= 2'd0;
                        if (w_count > c_MAX_WORDS) begin
                            err  <= 1'b1;
                            busy <= 1'b0;
                        end
                    end
                end
                L_DATA: begin
                    if (r_frameErr) begin
                        busy <= 1'b0;
                        done <= 1'b0;
                    end else if (r_byteValid) begin
                        if (w_lastByte) begin
                            we        <= 1'b1;
                            a         <= {14'd0, r_wordIdx, 2'b00};
                            wd        <= {r_rxShift, r_wordBuf};
                            r_wordIdx <= r_wordIdx + 16'd1;
                            r_byteIdx <= 2'd0;
                        end else begin
                            case (r_byteIdx)
                                2'd0:    r_wordBuf[7:0]   <= r_rxShift;
                                2'd1:    r_wordBuf[15:8]  <= r_rxShift;
                                default: r_wordBuf[23:16] <= r_rxShift;
                            endcase
                            r_byteIdx <= r_byteIdx + 2'd1;
                        end
                    end
                end
                L_DONE: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: busy <= 1'b0;
            endcase
        end
    end

    assign cpu_reset = reset | busy;

endmodule
`default_nettype wire

// File: tb/tb_imem_uart_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_uart_loader
// Description : Self-checking bench for imem_uart_loader (CLKS_PER_BIT=4).
//               Frame table plus hand-written glitch and mid-frame reset cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_uart_loader;

    localparam int c_CPB = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx = 1'b1;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic        busy;
    logic        cpuReset;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    imem_uart_loader #(
        .CLKS_PER_BIT (c_CPB),
        .MAX_WORDS    (64)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .we        (we),
        .a         (a),
        .wd        (wd),
        .busy      (busy),
        .cpu_reset (cpuReset),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Write-port monitor, sampled on the falling edge
    logic [31:0] wrA  [0:15];
    logic [31:0] wrWd [0:15];
    int          wrCount  = 0;
    logic        weLast   = 1'b0;
    logic        weDouble = 1'b0;

    always @(negedge clk) begin
        if (we) begin
            if (wrCount < 16) begin
                wrA[wrCount]  = a;
                wrWd[wrCount] = wd;
            end
            wrCount = wrCount + 1;
            if (weLast) weDouble = 1'b1;
        end
        weLast = we;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic sendByte(input logic [7:0] b, input logic stopBit);
        rx = 1'b0;
        repeat (c_CPB) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            rx = b[k];
            repeat (c_CPB) @(negedge clk);
        end
        rx = stopBit;
        repeat (c_CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    typedef struct {
        int          nBytes;
        logic [79:0] bytes;      // first byte in bits [7:0]
        logic        badLast;    // last byte sent with a low stop bit
        int          expWr;
        logic [31:0] expA0;
        logic [31:0] expWd0;
        logic [31:0] expA1;
        logic [31:0] expWd1;
        logic        expBusy;
        logic        expDone;
        logic        expErr;
        logic [31:0] holdA;
        logic [31:0] holdWd;
    } vec_t;

    vec_t vecs [0:4];

    initial begin
        int base;
        logic [7:0] b;

        vecs[0] = '{10, 80'h00100593_00A00513_0002, 1'b0, 2,
                    32'h0, 32'h00A00513, 32'h4, 32'h00100593,
                    1'b0, 1'b1, 1'b0, 32'h4, 32'h00100593};
        vecs[1] = '{2, 80'h0000, 1'b0, 0,
                    32'h0, 32'h0, 32'h0, 32'h0,
                    1'b0, 1'b1, 1'b0, 32'h4, 32'h00100593};
        vecs[2] = '{2, 80'h0041, 1'b0, 0,
                    32'h0, 32'h0, 32'h0, 32'h0,
                    1'b0, 1'b0, 1'b1, 32'h4, 32'h00100593};
        vecs[3] = '{6, 80'h12345678_0001, 1'b0, 1,
                    32'h0, 32'h12345678, 32'h0, 32'h0,
                    1'b0, 1'b1, 1'b1, 32'h0, 32'h12345678};
        vecs[4] = '{5, 80'h33_2211_0001, 1'b1, 0,
                    32'h0, 32'h0, 32'h0, 32'h0,
                    1'b0, 1'b0, 1'b1, 32'h0, 32'h12345678};

        // ---------------- reset state ----------------
        repeat (4) @(negedge clk);
        chk("rst_we", {31'd0, we}, 32'd0);
        chk("rst_a", a, 32'd0);
        chk("rst_wd", wd, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_cpu_reset", {31'd0, cpuReset}, 32'd1);
        reset = 1'b0;
        repeat (6) @(negedge clk);

        // ---------------- short low glitch ----------------
        base = wrCount;
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (50) @(negedge clk);
        chk("glitch_busy", {31'd0, busy}, 32'd0);
        chk("glitch_err", {31'd0, err}, 32'd0);
        chk("glitch_writes", wrCount - base, 0);

        // ---------------- frame table ----------------
        for (int i = 0; i < 5; i++) begin
            base = wrCount;
            for (int k = 0; k < vecs[i].nBytes; k++) begin
                b = vecs[i].bytes[8*k +: 8];
                sendByte(b, !(vecs[i].badLast && (k == vecs[i].nBytes - 1)));
            end
            repeat (20) @(negedge clk);
            chk($sformatf("v%0d_writes", i), wrCount - base, vecs[i].expWr);
            if (vecs[i].expWr > 0) begin
                chk($sformatf("v%0d_a0", i), wrA[base], vecs[i].expA0);
                chk($sformatf("v%0d_wd0", i), wrWd[base], vecs[i].expWd0);
            end
            if (vecs[i].expWr > 1) begin
                chk($sformatf("v%0d_a1", i), wrA[base+1], vecs[i].expA1);
                chk($sformatf("v%0d_wd1", i), wrWd[base+1], vecs[i].expWd1);
            end
            chk($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].expBusy});
            chk($sformatf("v%0d_cpu_reset", i), {31'd0, cpuReset}, {31'd0, vecs[i].expBusy});
            chk($sformatf("v%0d_done", i), {31'd0, done}, {31'd0, vecs[i].expDone});
            chk($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, vecs[i].expErr});
            chk($sformatf("v%0d_hold_a", i), a, vecs[i].holdA);
            chk($sformatf("v%0d_hold_wd", i), wd, vecs[i].holdWd);
        end

        // ---------------- reset in the middle of a frame ----------------
        base = wrCount;
        sendByte(8'h01, 1'b1);
        sendByte(8'h00, 1'b1);
        sendByte(8'hAA, 1'b1);
        sendByte(8'hBB, 1'b1);
        repeat (5) @(negedge clk);
        chk("mid_busy_before", {31'd0, busy}, 32'd1);
        chk("mid_cpu_reset_before", {31'd0, cpuReset}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_we", {31'd0, we}, 32'd0);
        chk("mid_busy", {31'd0, busy}, 32'd0);
        chk("mid_cpu_reset", {31'd0, cpuReset}, 32'd1);
        chk("mid_err_cleared", {31'd0, err}, 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_no_writes", wrCount - base, 0);
        sendByte(8'h01, 1'b1);
        sendByte(8'h00, 1'b1);
        sendByte(8'hEF, 1'b1);
        sendByte(8'hBE, 1'b1);
        sendByte(8'hAD, 1'b1);
        sendByte(8'hDE, 1'b1);
        repeat (20) @(negedge clk);
        chk("reload_writes", wrCount - base, 1);
        chk("reload_a", wrA[base], 32'h0);
        chk("reload_wd", wrWd[base], 32'hDEADBEEF);
        chk("reload_done", {31'd0, done}, 32'd1);
        chk("reload_busy", {31'd0, busy}, 32'd0);
        chk("reload_cpu_reset", {31'd0, cpuReset}, 32'd0);
        chk("reload_err", {31'd0, err}, 32'd0);

        chk("we_single_cycle", {31'd0, weDouble}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
